// File: rtl/processor_seg_mux.sv
// processor_seg_mux
// Avalon-MM slave that scans a bank of seven-segment digits (segments + dp).
// Each digit has its own pattern register. A programmable prescaler sets the
// scan rate, masked digits can blink, and segment/digit polarity is selectable.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     word address (0 CTRL, 1 DIVISOR, 2 BLINK_MASK, 3 STATUS, 4.. DIGITn)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, valid regardless of chipselect
//   seg_out     registered segment drive
//   dig_out     registered digit enables (one-hot when active)
module processor_seg_mux #(
  parameter int DIGITS      = 4,
  parameter int SEG_W       = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 49999,
  parameter int BLINK_TICKS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [SEG_W-1:0]  seg_out,
  output logic [DIGITS-1:0] dig_out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BC_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_TICKS - 1);

  // Register file
  logic [3:0]        ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIGITS-1:0] mask_q;
  logic [SEG_W-1:0]  digit_q [DIGITS];

  // Scan state
  logic [DIV_W-1:0]  pcnt_q, pcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;

  logic wr_en, ctrl_wr, div_wr, mask_wr, scan_rise, tick, blank;
  logic scan_en, blink_en, seg_al, dig_al;
  logic [DIGITS-1:0] digit_wr;
  logic unused_wdata;

  assign scan_en  = ctrl_q[0];
  assign blink_en = ctrl_q[1];
  assign seg_al   = ctrl_q[2];
  assign dig_al   = ctrl_q[3];

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == 4'd0);
  assign div_wr  = wr_en && (address == 4'd1);
  assign mask_wr = wr_en && (address == 4'd2);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
      assign digit_wr[gi] = wr_en && (address == 4'(4 + gi));
    end
  endgenerate

  // Turning scanning back on restarts the prescaler so the first step
  // arrives a full DIVISOR+1 cycles later.
  assign scan_rise = ctrl_wr && writedata[0] && !scan_en;
  assign tick      = scan_en && (pcnt_q == div_q);
  assign blank     = blink_en & phase_q & mask_q[idx_q];
  assign unused_wdata = ^writedata;

  always_comb begin
    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    // A tick coinciding with a DIVISOR write still advances idx/bcnt below.
    if (div_wr || scan_rise || tick) begin
      pcnt_d = '0;
    end else if (scan_en) begin
      pcnt_d = pcnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (bcnt_q == BC_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    if (scan_en) begin
      seg_d = (blank ? '0 : digit_q[idx_q]) ^ {SEG_W{seg_al}};
      dig_d = (DIGITS'(1) << idx_q) ^ {DIGITS{dig_al}};
    end else begin
      seg_d = {SEG_W{seg_al}};
      dig_d = {DIGITS{dig_al}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 4'h1;
      div_q   <= DIV_W'(DEFAULT_DIV);
      mask_q  <= '0;
      pcnt_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= '0;
      dig_q   <= '0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
    end else begin
      if (ctrl_wr) ctrl_q <= writedata[3:0];
      if (div_wr)  div_q  <= writedata[DIV_W-1:0];
      if (mask_wr) mask_q <= writedata[DIGITS-1:0];
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_wr[i]) digit_q[i] <= writedata[SEG_W-1:0];
      end
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata[3:0]        = ctrl_q;
      4'd1: readdata[DIV_W-1:0]  = div_q;
      4'd2: readdata[DIGITS-1:0] = mask_q;
      4'd3: begin
        readdata[IDX_W-1:0] = idx_q;
        readdata[8]         = phase_q;
      end
      default: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (address == 4'(4 + i)) readdata[SEG_W-1:0] = digit_q[i];
        end
      end
    endcase
  end

  assign seg_out = seg_q;
  assign dig_out = dig_q;

endmodule
